// File: rtl/usb_tx_encoder.sv
// USB full-speed serial transmit encoder: SYNC, LSB-first payload, bit
// stuffing, NRZI and EOP, driven straight onto D+/D-.
// Optional CRC16 trailer enabled by defining USB_TX_CRC16_EN.
module usb_tx_encoder #(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       tx_start,
    input  logic       tx_nodata,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_error,
    output logic       d_plus,
    output logic       d_minus
);

    localparam int            CW       = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_DATA,
`ifdef USB_TX_CRC16_EN
        ST_CRC,
`endif
        ST_EOP_SE0,
        ST_EOP_J
    } state_t;

    state_t        r_state, w_state;
    logic [CW-1:0] r_bitCnt, w_bitCnt;
    logic [3:0]    r_bitIdx, w_bitIdx;
    logic [3:0]    w_nextIdx, w_lastIdx;
    logic [2:0]    r_ones, w_ones;
    logic          r_levelK, w_levelK;
    logic          r_se0, w_se0;
    logic          r_nodata, w_nodata;
    logic          r_last, w_last;
    logic [7:0]    r_byte, w_byte;
    logic          w_boundary, w_stuffDue, w_unitEnd, w_wantByte;
    logic          w_emit, w_emitBit;
`ifdef USB_TX_CRC16_EN
    logic [15:0]   r_crc, w_crc;
    logic          w_emitPayload, w_fb;
`endif

    // r_bitIdx is the index of the last real (non-stuff) bit on the line, so a
    // unit ends once that index is reached and no stuff bit is still owed.
    always_comb begin
        w_lastIdx = 4'd7;
`ifdef USB_TX_CRC16_EN
        if (r_state == ST_CRC) begin
            w_lastIdx = 4'd15;
        end
`endif
        w_boundary = (r_bitCnt == LAST_CNT);
        w_nextIdx  = r_bitIdx + 4'd1;
        w_stuffDue = (r_ones == 3'd6);
        w_unitEnd  = (r_bitIdx == w_lastIdx) && !w_stuffDue;
        w_wantByte = w_boundary && w_unitEnd &&
                     (((r_state == ST_SYNC) && !r_nodata) ||
                      ((r_state == ST_DATA) && !r_last));
    end

    assign tx_ready = w_wantByte;
    assign tx_error = w_wantByte && !tx_valid;
    assign tx_done  = (r_state == ST_EOP_J) && w_boundary;
    assign tx_busy  = (r_state != ST_IDLE) && !tx_done;
    assign d_plus   = !r_se0 && !r_levelK;
    assign d_minus  = !r_se0 && r_levelK;

    // Next-state logic: picks the next bit at each bit boundary, then NRZI-encodes it and tracks the ones run.
    always_comb begin
        w_state   = r_state;
        w_bitCnt  = r_bitCnt;
        w_bitIdx  = r_bitIdx;
        w_ones    = r_ones;
        w_levelK  = r_levelK;
        w_se0     = r_se0;
        w_nodata  = r_nodata;
        w_last    = r_last;
        w_byte    = r_byte;
        w_emit    = 1'b0;
        w_emitBit = 1'b0;
`ifdef USB_TX_CRC16_EN
        w_crc         = r_crc;
        w_emitPayload = 1'b0;
        w_fb          = 1'b0;
`endif
        if (r_state == ST_IDLE) begin
            w_bitCnt = '0;
            if (tx_start) begin
                w_state   = ST_SYNC;
                w_bitIdx  = 4'd0;
                w_nodata  = tx_nodata;
                w_emit    = 1'b1;
                w_emitBit = 1'b0;
`ifdef USB_TX_CRC16_EN
                w_crc     = 16'hFFFF;
`endif
            end
        end else if (!w_boundary) begin
            w_bitCnt = r_bitCnt + 1'b1;
        end else begin
            w_bitCnt = '0;
            case (r_state)
                ST_SYNC, ST_DATA: begin
                    if (w_stuffDue) begin
                        w_emit    = 1'b1;
                        w_emitBit = 1'b0;
                    end else if (!w_unitEnd) begin
                        w_bitIdx  = w_nextIdx;
                        w_emit    = 1'b1;
                        w_emitBit = (r_state == ST_SYNC) ? (w_nextIdx == 4'd7)
                                                         : r_byte[w_nextIdx[2:0]];
`ifdef USB_TX_CRC16_EN
                        w_emitPayload = (r_state == ST_DATA);
`endif
                    end else if (w_wantByte && tx_valid) begin
                        w_state   = ST_DATA;
                        w_byte    = tx_data;
                        w_last    = tx_last;
                        w_bitIdx  = 4'd0;
                        w_emit    = 1'b1;
                        w_emitBit = tx_data[0];
`ifdef USB_TX_CRC16_EN
                        w_emitPayload = 1'b1;
`endif
                    end else if (w_wantByte) begin
                        w_state  = ST_EOP_SE0;
                        w_se0    = 1'b1;
                        w_bitIdx = 4'd0;
                        w_ones   = 3'd0;
                    end else begin
`ifdef USB_TX_CRC16_EN
                        w_state   = ST_CRC;
                        w_bitIdx  = 4'd0;
                        w_emit    = 1'b1;
                        w_emitBit = ~r_crc[15];
`else
                        w_state  = ST_EOP_SE0;
                        w_se0    = 1'b1;
                        w_bitIdx = 4'd0;
                        w_ones   = 3'd0;
`endif
                    end
                end
`ifdef USB_TX_CRC16_EN
                ST_CRC: begin
                    if (w_stuffDue) begin
                        w_emit    = 1'b1;
                        w_emitBit = 1'b0;
                    end else if (!w_unitEnd) begin
                        w_bitIdx  = w_nextIdx;
                        w_emit    = 1'b1;
                        w_emitBit = ~r_crc[4'd15 - w_nextIdx];
                    end else begin
                        w_state  = ST_EOP_SE0;
                        w_se0    = 1'b1;
                        w_bitIdx = 4'd0;
                        w_ones   = 3'd0;
                    end
                end
`endif
                ST_EOP_SE0: begin
                    if (r_bitIdx == 4'd0) begin
                        w_bitIdx = 4'd1;
                    end else begin
                        w_state  = ST_EOP_J;
                        w_se0    = 1'b0;
                        w_levelK = 1'b0;
                        w_bitIdx = 4'd0;
                    end
                end
                ST_EOP_J: begin
                    w_state  = ST_IDLE;
                    w_bitIdx = 4'd0;
                    w_ones   = 3'd0;
                end
                default: begin
                    w_state = ST_IDLE;
                end
            endcase
        end
        if (w_emit) begin
            w_levelK = r_levelK ^ !w_emitBit;
            w_ones   = w_emitBit ? (r_ones + 3'd1) : 3'd0;
`ifdef USB_TX_CRC16_EN
            if (w_emitPayload) begin
                w_fb  = w_emitBit ^ r_crc[15];
                w_crc = {r_crc[14:0], 1'b0} ^ (w_fb ? 16'h8005 : 16'h0000);
            end
`endif
        end
    end

    // State and datapath registers; reset forces idle J on the line immediately.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state  <= ST_IDLE;
            r_bitCnt <= '0;
            r_bitIdx <= 4'd0;
            r_ones   <= 3'd0;
            r_levelK <= 1'b0;
            r_se0    <= 1'b0;
            r_nodata <= 1'b0;
            r_last   <= 1'b0;
            r_byte   <= 8'h00;
`ifdef USB_TX_CRC16_EN
            r_crc    <= 16'h0000;
`endif
        end else begin
            r_state  <= w_state;
            r_bitCnt <= w_bitCnt;
            r_bitIdx <= w_bitIdx;
            r_ones   <= w_ones;
            r_levelK <= w_levelK;
            r_se0    <= w_se0;
            r_nodata <= w_nodata;
            r_last   <= w_last;
            r_byte   <= w_byte;
`ifdef USB_TX_CRC16_EN
            r_crc    <= w_crc;
`endif
        end
    end

endmodule

// File: tb/tb_usb_tx_encoder.sv
// Testbench for usb_tx_encoder: table of whole-packet vectors with
// hand-computed line sequences, plus hand-written reset/restart sequences.
module tb_usb_tx_encoder;

    localparam int CPB        = 8;
    localparam int MAX_CYCLES = 2000;
`ifdef USB_TX_CRC16_EN
    localparam int ZERO_LEN_PERIODS = 27;
`else
    localparam int ZERO_LEN_PERIODS = 11;
`endif

    logic       clk       = 1'b0;
    logic       n_rst     = 1'b0;
    logic       tx_start  = 1'b0;
    logic       tx_nodata = 1'b0;
    logic [7:0] tx_data   = 8'h00;
    logic       tx_valid  = 1'b0;
    logic       tx_last   = 1'b0;
    logic       tx_ready, tx_busy, tx_done, tx_error, d_plus, d_minus;

    typedef struct {
        string      name;
        logic       nodata;
        int         nBytes;
        logic [7:0] b0;
        logic [7:0] b1;
        int         validCount;
        string      expLine;
        int         expReady;
        int         expError;
    } vector_t;

    vector_t    vectors[$];
    logic [1:0] lineLog[$];
    int         readyCycles[$];
    int         errCount;
    int         doneCycle;
    logic [2:0] postState;
    int         checks = 0;
    int         passes = 0;

    usb_tx_encoder #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .n_rst(n_rst), .tx_start(tx_start), .tx_nodata(tx_nodata),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last),
        .tx_ready(tx_ready), .tx_busy(tx_busy), .tx_done(tx_done),
        .tx_error(tx_error), .d_plus(d_plus), .d_minus(d_minus)
    );

    always #5 clk = ~clk;

    task automatic applyStimulus(input logic start, input logic nodata, input logic [7:0] data,
                                 input logic valid, input logic last);
        tx_start  = start;
        tx_nodata = nodata;
        tx_data   = data;
        tx_valid  = valid;
        tx_last   = last;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual == expected) passes++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    task automatic checkText(input string name, input string actual, input string expected);
        checks++;
        if (actual == expected) passes++;
        else $display("[TB] FAIL %s: got %s, expected %s", name, actual, expected);
    endtask

    function automatic string lineChar(input logic [1:0] lv);
        case (lv)
            2'b10:   return "J";
            2'b01:   return "K";
            2'b00:   return "0";
            default: return "X";
        endcase
    endfunction

    function automatic string buildLine(input int offset);
        string s;
        s = "";
        for (int p = 0; p * CPB + offset < lineLog.size(); p++)
            s = {s, lineChar(lineLog[p * CPB + offset])};
        return s;
    endfunction

    // Independent NRZI decode + destuff of the logged line; returns first 16 payload bits.
    function automatic logic [15:0] decodePayload();
        logic [1:0]  prevLv;
        logic [1:0]  lv;
        logic        b;
        int          ones;
        int          realBits;
        int          got;
        logic [15:0] val;
        prevLv = 2'b10; ones = 0; realBits = 0; got = 0; val = 16'h0000;
        for (int p = 0; p * CPB < lineLog.size(); p++) begin
            lv = lineLog[p * CPB];
            if (lv == 2'b00) break;
            b = (lv == prevLv);
            prevLv = lv;
            if (ones == 6) begin
                ones = 0;
                continue;
            end
            if (realBits >= 8 && got < 16) begin
                val[got] = b;
                got++;
            end
            realBits++;
            ones = b ? ones + 1 : 0;
        end
        return val;
    endfunction

    function automatic void addVector(input string name, input logic nodata, input int nBytes,
                                      input logic [7:0] b0, input logic [7:0] b1, input int validCount,
                                      input string expLine, input int expReady, input int expError);
        vector_t v;
        v.name = name; v.nodata = nodata; v.nBytes = nBytes; v.b0 = b0; v.b1 = b1;
        v.validCount = validCount; v.expLine = expLine; v.expReady = expReady; v.expError = expError;
        vectors.push_back(v);
    endfunction

    // Drives one packet, serving bytes on tx_ready, logging the line each cycle until tx_done.
    task automatic runPacket(input logic nodata, input int nBytes, input logic [7:0] b0,
                             input logic [7:0] b1, input int validCount,
                             input int extraStartA, input int extraStartB);
        int   sent;
        logic adv;
        lineLog.delete();
        readyCycles.delete();
        errCount  = 0;
        doneCycle = -1;
        sent      = 0;
        adv       = 1'b0;
        @(posedge clk); #1;
        applyStimulus(1'b1, nodata, b0, validCount > 0, nBytes == 1);
        for (int c = 0; c < MAX_CYCLES; c++) begin
            @(posedge clk); #1;
            if (adv) begin
                sent++;
                applyStimulus(1'b0, nodata, (sent == 1) ? b1 : 8'h00,
                              (sent < validCount) && (sent < nBytes), sent == nBytes - 1);
                adv = 1'b0;
            end
            tx_start = (c == extraStartA) || (c == extraStartB);
            @(negedge clk);
            lineLog.push_back({d_plus, d_minus});
            if (tx_ready) begin
                readyCycles.push_back(c);
                adv = 1'b1;
            end
            if (tx_error) errCount++;
            if (tx_done) begin
                doneCycle = c;
                break;
            end
        end
        if (doneCycle < 0) checkOutput("doneTimeout", doneCycle, 0);
        @(posedge clk); #1;
        tx_start = 1'b0;
        tx_valid = 1'b0;
        @(negedge clk);
        postState = {d_plus, d_minus, tx_busy};
    endtask

    task automatic checkIdleHold(input string name, input int n);
        int bad;
        bad = 0;
        repeat (n) begin
            @(negedge clk);
            if ({d_plus, d_minus, tx_busy} != 3'b100) bad++;
        end
        checkOutput(name, bad, 0);
    endtask

    initial begin
        int firstReady;
        int waitCnt;

`ifdef USB_TX_CRC16_EN
        addVector("zeroLenCrc", 1'b1, 0, 8'h00, 8'h00, 0,
                  "KJKJKJKKJKJKJKJKJKJKJKJK00J", 0, 0);
`else
        addVector("zeroLen",    1'b1, 0, 8'h00, 8'h00, 0, "KJKJKJKK00J", 0, 0);
        addVector("byteFF",     1'b0, 1, 8'hFF, 8'h00, 1, "KJKJKJKKKKKKKJJJJ00J", 1, 0);
        addVector("pairA53C",   1'b0, 2, 8'hA5, 8'h3C, 2, "KJKJKJKKKJJKJJKKJKKKKKJK00J", 2, 0);
        addVector("stuffAtEnd", 1'b0, 1, 8'hFC, 8'h00, 1, "KJKJKJKKJKKKKKKKJ00J", 1, 0);
`endif
        addVector("underrun",   1'b0, 2, 8'h12, 8'h00, 1, "KJKJKJKKJJKJJKJK00J", 2, 1);

        // Reset state and idle hold
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("resetOutputs", {d_plus, d_minus, tx_busy, tx_ready, tx_done, tx_error}, 6'b100000);
        @(posedge clk); #1;
        n_rst = 1'b1;
        checkIdleHold("idleAfterReset", 20);

        // Table of whole packets
        foreach (vectors[i]) begin
            runPacket(vectors[i].nodata, vectors[i].nBytes, vectors[i].b0, vectors[i].b1,
                      vectors[i].validCount, -1, -1);
            checkText({vectors[i].name, ".lineFirst"}, buildLine(0), vectors[i].expLine);
            checkText({vectors[i].name, ".lineLast"}, buildLine(CPB - 1), vectors[i].expLine);
            checkOutput({vectors[i].name, ".doneCycle"}, doneCycle, vectors[i].expLine.len() * CPB - 1);
            checkOutput({vectors[i].name, ".readyCount"}, readyCycles.size(), vectors[i].expReady);
            checkOutput({vectors[i].name, ".errorCount"}, errCount, vectors[i].expError);
            firstReady = (readyCycles.size() > 0) ? readyCycles[0] : -1;
            if (vectors[i].expReady > 0)
                checkOutput({vectors[i].name, ".firstReady"}, firstReady, 8 * CPB - 1);
            checkOutput({vectors[i].name, ".postIdle"}, postState, 3'b100);
        end

        // Back-to-back bytes: ready spacing and decoded payload
        runPacket(1'b0, 2, 8'hA5, 8'h3C, 2, -1, -1);
        checkOutput("pair.readySpacing",
                    (readyCycles.size() >= 2) ? readyCycles[1] - readyCycles[0] : -1, 8 * CPB);
        checkOutput("pair.decoded", decodePayload(), 16'h3CA5);

        // Starts while busy and coincident with tx_done are ignored; next cycle is accepted
        runPacket(1'b1, 0, 8'h00, 8'h00, 0, 30, ZERO_LEN_PERIODS * CPB - 1);
        checkOutput("ignoredStarts.doneCycle", doneCycle, ZERO_LEN_PERIODS * CPB - 1);
        checkOutput("ignoredStarts.postIdle", postState, 3'b100);
        applyStimulus(1'b1, 1'b1, 8'h00, 1'b0, 1'b0);
        @(posedge clk); #1;
        tx_start = 1'b0;
        @(negedge clk);
        checkOutput("restart.busyAndK", {tx_busy, d_plus, d_minus}, 3'b101);
        waitCnt = 0;
        while (!tx_done && waitCnt < MAX_CYCLES) begin
            @(negedge clk);
            waitCnt++;
        end
        checkOutput("restart.doneSeen", tx_done, 1);

        // Asynchronous reset in the middle of a data byte
        @(posedge clk); #1;
        applyStimulus(1'b1, 1'b0, 8'hA5, 1'b1, 1'b0);
        @(posedge clk); #1;
        tx_start = 1'b0;
        repeat (80) @(posedge clk);
        #1;
        checkOutput("midData.busyBefore", tx_busy, 1);
        n_rst = 1'b0;
        #1;
        checkOutput("midData.resetOutputs", {d_plus, d_minus, tx_busy, tx_ready, tx_done, tx_error}, 6'b100000);
        tx_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_rst = 1'b1;
        checkIdleHold("midData.idleAfterRelease", 24);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
